cb_shadow: RTL and testbench
============================

# cb_shadow

Double-buffered, N-LE connection box: second-generation CB tile between switchbox tracks and logic elements. A single config chain shifts into a shadow register while the active configuration keeps driving the fabric. The whole tile then switches atomically on a commit strobe, so reconfiguration does not interrupt operation. Adds a parametrised LE count, per-input registered sampling, length checking and track-conflict detection.

## Interface
- WIDTH, 32: switchbox tracks.
- NUM_LE, 2: LEs served.
- LE_INPUTS, 4: inputs per LE.
- LE_OUTPUTS, 1: outputs per LE.
- Derived values:
  - SEL_BITS = $clog2(WIDTH+2).
  - PER_LE = (LE_INPUTS+LE_OUTPUTS)*SEL_BITS + LE_INPUTS.
  - CFG_BITS = NUM_LE*PER_LE.

- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- en, in, 1: tile enable; gates FSM, shifting and input flops.
- config_en, in, 1: shift request.
- config_data_in, in, 1: serial config in.
- config_data_out, in→out, 1: shadow[CFG_BITS-1] (daisy chain).
- config_commit, in, 1: commit strobe.
- config_done, out, 1: one-cycle pulse when new config is live.
- config_err, out, 1: sticky short-chain error.
- config_conflict, out, 1: active config has two output muxes on one track.
- sb_bus_in, in, WIDTH: tracks into the CB.
- sb_bus_out, out, WIDTH: tracks driven by LE outputs.
- le_out, in, NUM_LE*LE_OUTPUTS: flat index n*LE_OUTPUTS+o.
- le_in, out, NUM_LE*LE_INPUTS: flat index n*LE_INPUTS+i.

## Operation
- Shadow shifting:
  - Shift left, config_data_in into bit 0, when en && config_en.
  - Host sends MSB first.
- Field layout, for LE n with base b = n*PER_LE:
  - Input select i: [b+i*SEL_BITS +: SEL_BITS].
  - Output select o: [b+(LE_INPUTS+o)*SEL_BITS +: SEL_BITS].
  - Reg bit i: [b+(LE_INPUTS+LE_OUTPUTS)*SEL_BITS+i].
- Input select decode:
  - Value < WIDTH: sb_bus_in[sel].
  - WIDTH: constant 0.
  - WIDTH+1: constant 1.
  - Any other value: 0.
- Input path: reg bit 1 means le_in comes from a flop loading the mux result when en=1; reg bit 0 means the combinational mux.
- Output select: value < WIDTH drives track sel with the LE output; any other value drives nothing.
  - Undriven track = 0.
  - Multiple drivers on one track: the lowest flat output index wins.
- config_conflict: computed from shadow at commit, registered with active.
- Shifting never alters active config or le_in/sb_bus_out.
- FSM states: IDLE, SHIFT, COMMIT; bit counter saturates at CFG_BITS.
  - IDLE: en&&config_en → SHIFT, count=1, config_err cleared. config_commit is ignored (no error).
  - SHIFT, en&&config_en: shift, count++ (saturating).
  - SHIFT, en&&config_commit&&!config_en, count==CFG_BITS: active←shadow → COMMIT.
  - SHIFT, en&&config_commit&&!config_en, count<CFG_BITS: config_err←1, active unchanged → IDLE.
  - COMMIT: config_done=1 for exactly this cycle, inputs ignored → IDLE.
- config_en && config_commit together: shift wins, commit ignored.
- Extra bits beyond CFG_BITS: pass through to config_data_out. Count stays saturated; the last CFG_BITS bits are kept.

## Timing
- Reset state:
  - State IDLE, count 0.
  - Shadow all ones.
  - Active: every select = WIDTH, reg bits 0.
  - Input flops 0, config_done/err/conflict 0.
- Resulting outputs after reset: le_in=0, sb_bus_out=0, config_data_out=1.
- Reset mid-shift or mid-commit returns to the reset state immediately; a partial chain is discarded.
- Shift: config_data_out shows the new MSB after the same edge.
- Commit: strobe sampled at edge N. New active config, config_done and config_conflict are visible after edge N; combinational le_in and sb_bus_out follow in the same cycle. config_done drops after edge N+1.
- Registered inputs: one-cycle latency; they hold while en=0.
- en=0: FSM, counter, shadow and input flops frozen. Combinational paths stay live.

## Test plan
All scenarios use WIDTH=8, SEL_BITS=4, NUM_LE=2, LE_INPUTS=4, LE_OUTPUTS=1, CFG_BITS=48.
- Reset and idle:
  - Stimulus: rst pulse, then sb_bus_in=8'hFF, le_out=2'b11.
  - Response: le_in=0, sb_bus_out=0, config_data_out=1, done/err/conflict=0.
- Live reconfiguration:
  - Stimulus: commit config A (LE0 in0←track3, LE0 out→track5). While holding sb_bus_in[3]=1 and le_out[0]=1, shift 48 bits of config B.
  - Response: during the shift le_in[0]=1 and sb_bus_out=8'h20 unchanged.
  - On commit: config_done is a one-cycle pulse and outputs switch to config B.
- Short chain:
  - Stimulus: shift 47 bits, then commit.
  - Response: config_err=1, active unchanged, no config_done; err clears on the next shift start.
- Conflict and priority:
  - Stimulus: both LE outputs select track 2; le_out=2'b10.
  - Response: config_conflict=1, sb_bus_out[2]=0 (LE0 wins). With le_out=2'b01: sb_bus_out[2]=1.
- Constants and registered mode:
  - Stimulus: LE1 in0 select 8, in1 select 9, in2 track0 with reg bit 1; toggle sb_bus_in[0].
  - Response: le_in[4]=0, le_in[5]=1, le_in[6] follows one cycle later; it holds while en=0.
- Reset mid-shift:
  - Stimulus: assert rst after 20 bits shifted.
  - Response: shadow all ones, count 0. The following 48-bit shift and commit succeeds with err=0.

Source files
------------

// File: rtl/cb_shadow.sv
// cb_shadow: double-buffered connection box between switchbox tracks and NUM_LE logic elements.
// Latency: serial config shifts into a shadow chain while the active config drives the fabric; commit
//          swaps in the whole shadow in one edge. Combinational routing is zero-cycle, registered inputs one cycle.
// Flow control: none; en freezes the FSM, counter, shadow and input flops, combinational paths stay live.
//
// Ports:
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   en                : tile enable (gates FSM, shifting and input flops)
//   config_en         : shift request, config_data_in enters shadow bit 0 (host sends MSB first)
//   config_data_out   : shadow MSB, for daisy-chaining tiles
//   config_commit     : commit strobe, accepted only after exactly a full chain has been shifted
//   config_done       : one-cycle pulse in the cycle the new config becomes live
//   config_err        : sticky short-chain error, cleared when the next shift starts
//   config_conflict   : the active config routes two LE outputs to the same track
//   sb_bus_in/out     : switchbox tracks in / tracks driven by LE outputs
//   le_out / le_in    : LE outputs (flat n*LE_OUTPUTS+o) / LE inputs (flat n*LE_INPUTS+i)
module cb_shadow #(
    parameter int WIDTH      = 32,
    parameter int NUM_LE     = 2,
    parameter int LE_INPUTS  = 4,
    parameter int LE_OUTPUTS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         config_en,
    input  logic                         config_data_in,
    output logic                         config_data_out,
    input  logic                         config_commit,
    output logic                         config_done,
    output logic                         config_err,
    output logic                         config_conflict,
    input  logic [WIDTH-1:0]             sb_bus_in,
    output logic [WIDTH-1:0]             sb_bus_out,
    input  logic [NUM_LE*LE_OUTPUTS-1:0] le_out,
    output logic [NUM_LE*LE_INPUTS-1:0]  le_in
);

    localparam int SEL_BITS = $clog2(WIDTH + 2);
    localparam int PER_LE   = (LE_INPUTS + LE_OUTPUTS) * SEL_BITS + LE_INPUTS;
    localparam int CFG_BITS = NUM_LE * PER_LE;
    localparam int CNT_BITS = $clog2(CFG_BITS + 1);
    localparam int NUM_IN   = NUM_LE * LE_INPUTS;
    localparam int NUM_OUT  = NUM_LE * LE_OUTPUTS;

    // Select code WIDTH means "constant 0" for inputs and "not driving" for outputs,
    // so it is the safe power-up value for every select field.
    localparam logic [SEL_BITS-1:0] SEL_CONST0 = SEL_BITS'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Field accessors on a CFG_BITS-wide configuration image
    // ------------------------------------------------------------------
    function automatic logic [SEL_BITS-1:0] in_sel(input logic [CFG_BITS-1:0] cfg,
                                                   input int n, input int i);
        return cfg[n*PER_LE + i*SEL_BITS +: SEL_BITS];
    endfunction

    function automatic logic [SEL_BITS-1:0] out_sel(input logic [CFG_BITS-1:0] cfg,
                                                    input int n, input int o);
        return cfg[n*PER_LE + (LE_INPUTS + o)*SEL_BITS +: SEL_BITS];
    endfunction

    function automatic logic reg_bit(input logic [CFG_BITS-1:0] cfg,
                                     input int n, input int i);
        return cfg[n*PER_LE + (LE_INPUTS + LE_OUTPUTS)*SEL_BITS + i];
    endfunction

    // Active image after reset: all selects = constant-0 / undriven, all inputs combinational.
    function automatic logic [CFG_BITS-1:0] active_reset_value();
        logic [CFG_BITS-1:0] v;
        v = '0;
        for (int n = 0; n < NUM_LE; n++) begin
            for (int s = 0; s < LE_INPUTS + LE_OUTPUTS; s++) begin
                v[n*PER_LE + s*SEL_BITS +: SEL_BITS] = SEL_CONST0;
            end
        end
        return v;
    endfunction

    localparam logic [CFG_BITS-1:0] ACTIVE_RST = active_reset_value();

    // Input select decode: tracks, then constant 0, constant 1; unused codes read as 0.
    function automatic logic decode_in(input logic [SEL_BITS-1:0] sel,
                                       input logic [WIDTH-1:0] bus);
        logic v;
        v = 1'b0;
        for (int t = 0; t < WIDTH; t++) begin
            if (int'(sel) == t) begin
                v = bus[t];
            end
        end
        if (int'(sel) == WIDTH + 1) begin
            v = 1'b1;
        end
        return v;
    endfunction

    // Two output muxes aimed at the same real track; off-fabric codes never conflict.
    function automatic logic has_conflict(input logic [CFG_BITS-1:0] cfg);
        logic c;
        logic [SEL_BITS-1:0] sa;
        logic [SEL_BITS-1:0] sb;
        c = 1'b0;
        for (int a = 0; a < NUM_OUT; a++) begin
            for (int b = a + 1; b < NUM_OUT; b++) begin
                sa = out_sel(cfg, a / LE_OUTPUTS, a % LE_OUTPUTS);
                sb = out_sel(cfg, b / LE_OUTPUTS, b % LE_OUTPUTS);
                if ((sa == sb) && (int'(sa) < WIDTH)) begin
                    c = 1'b1;
                end
            end
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q,    state_d;
    logic [CNT_BITS-1:0]   count_q,    count_d;
    logic [CFG_BITS-1:0]   shadow_q,   shadow_d;
    logic [CFG_BITS-1:0]   active_q,   active_d;
    logic                  err_q,      err_d;
    logic                  conflict_q, conflict_d;
    logic [NUM_IN-1:0]     in_q,       in_d;
    logic [NUM_IN-1:0]     mux_val;

    // ------------------------------------------------------------------
    // Config FSM. A shift request always beats a simultaneous commit.
    // ------------------------------------------------------------------
    always_comb begin
        logic do_shift;
        state_d    = state_q;
        count_d    = count_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        err_d      = err_q;
        conflict_d = conflict_q;
        do_shift   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Commit strobes with no chain in flight are silently ignored.
                if (en && config_en) begin
                    do_shift = 1'b1;
                    count_d  = CNT_BITS'(1);
                    err_d    = 1'b0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (en && config_en) begin
                    do_shift = 1'b1;
                    // Saturate: surplus bits fall out of config_data_out and the
                    // most recent CFG_BITS bits remain, which is still a full chain.
                    if (count_q != CNT_BITS'(CFG_BITS)) begin
                        count_d = count_q + CNT_BITS'(1);
                    end
                end else if (en && config_commit) begin
                    if (count_q == CNT_BITS'(CFG_BITS)) begin
                        active_d   = shadow_q;
                        conflict_d = has_conflict(shadow_q);
                        state_d    = S_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_COMMIT: begin
                // Exactly one done cycle regardless of en or requests.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_shift) begin
            shadow_d = {shadow_q[CFG_BITS-2:0], config_data_in};
        end
    end

    // ------------------------------------------------------------------
    // Input routing: select decode, optional sampling flop per LE input
    // ------------------------------------------------------------------
    always_comb begin
        mux_val = '0;
        le_in   = '0;
        for (int n = 0; n < NUM_LE; n++) begin
            for (int i = 0; i < LE_INPUTS; i++) begin
                mux_val[n*LE_INPUTS + i] = decode_in(in_sel(active_q, n, i), sb_bus_in);
                le_in[n*LE_INPUTS + i]   = reg_bit(active_q, n, i) ? in_q[n*LE_INPUTS + i]
                                                                   : mux_val[n*LE_INPUTS + i];
            end
        end
    end

    // Flops sample every input continuously so switching an input to registered
    // mode picks up an already-current value.
    assign in_d = en ? mux_val : in_q;

    // ------------------------------------------------------------------
    // Output routing: first (lowest flat index) output aimed at a track owns it
    // ------------------------------------------------------------------
    always_comb begin
        logic [WIDTH-1:0] taken;
        sb_bus_out = '0;
        taken      = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            for (int t = 0; t < WIDTH; t++) begin
                if ((int'(out_sel(active_q, k / LE_OUTPUTS, k % LE_OUTPUTS)) == t) && !taken[t]) begin
                    sb_bus_out[t] = le_out[k];
                    taken[t]      = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            shadow_q   <= '1;
            active_q   <= ACTIVE_RST;
            err_q      <= 1'b0;
            conflict_q <= 1'b0;
            in_q       <= '0;
        end else if (en) begin
            state_q    <= state_d;
            count_q    <= count_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            err_q      <= err_d;
            conflict_q <= conflict_d;
            in_q       <= in_d;
        end else begin
            // Frozen tile still lets a pending done pulse retire.
            state_q    <= (state_q == S_COMMIT) ? S_IDLE : state_q;
            in_q       <= in_q;
        end
    end

    assign config_data_out = shadow_q[CFG_BITS-1];
    assign config_done     = (state_q == S_COMMIT);
    assign config_err      = err_q;
    assign config_conflict = conflict_q;

endmodule

// File: tb/tb_cb_shadow.sv
module tb_cb_shadow;

    localparam int W   = 8;
    localparam int NLE = 2;
    localparam int LI  = 4;
    localparam int LO  = 1;
    localparam int PER = 24;
    localparam int CB  = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          config_en;
    logic          config_data_in;
    logic          config_data_out;
    logic          config_commit;
    logic          config_done;
    logic          config_err;
    logic          config_conflict;
    logic [W-1:0]  sb_bus_in;
    logic [W-1:0]  sb_bus_out;
    logic [1:0]    le_out;
    logic [7:0]    le_in;

    always #5 clk = ~clk;

    cb_shadow #(.WIDTH(W), .NUM_LE(NLE), .LE_INPUTS(LI), .LE_OUTPUTS(LO)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .config_en       (config_en),
        .config_data_in  (config_data_in),
        .config_data_out (config_data_out),
        .config_commit   (config_commit),
        .config_done     (config_done),
        .config_err      (config_err),
        .config_conflict (config_conflict),
        .sb_bus_in       (sb_bus_in),
        .sb_bus_out      (sb_bus_out),
        .le_out          (le_out),
        .le_in           (le_in)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (config as decoded field arrays) ----------------
    int m_in_sel[8];
    int m_out_sel[2];
    bit m_reg[8];
    bit m_flop[8];
    bit hist[$];      // every bit ever shifted, trimmed to the last 48 (oldest = chain MSB)
    bit m_sess;       // a chain is in flight
    int m_cnt;
    bit m_err, m_done, m_conf;

    // config being built by the stimulus
    int c_in[8];
    int c_out[2];
    bit c_reg[8];

    function automatic void model_reset();
        hist.delete();
        for (int j = 0; j < CB; j++) hist.push_back(1'b1);
        for (int k = 0; k < 8; k++) begin m_in_sel[k] = W; m_reg[k] = 0; m_flop[k] = 0; end
        for (int k = 0; k < 2; k++) m_out_sel[k] = W;
        m_sess = 0; m_cnt = 0; m_err = 0; m_done = 0; m_conf = 0;
    endfunction

    function automatic void cfg_default();
        for (int k = 0; k < 8; k++) begin c_in[k] = W; c_reg[k] = 0; end
        for (int k = 0; k < 2; k++) c_out[k] = W;
    endfunction

    function automatic logic [47:0] pack_cfg();
        logic [47:0] v;
        v = '0;
        for (int n = 0; n < NLE; n++) begin
            for (int i = 0; i < LI; i++) begin
                v[n*PER + i*4 +: 4] = 4'(c_in[n*LI + i]);
                v[n*PER + 20 + i]   = c_reg[n*LI + i];
            end
            v[n*PER + 16 +: 4] = 4'(c_out[n]);
        end
        return v;
    endfunction

    function automatic void load_active();
        logic [47:0] v;
        for (int j = 0; j < CB; j++) v[47-j] = hist[j];
        for (int n = 0; n < NLE; n++) begin
            for (int i = 0; i < LI; i++) begin
                m_in_sel[n*LI + i] = int'(v[n*PER + i*4 +: 4]);
                m_reg[n*LI + i]    = v[n*PER + 20 + i];
            end
            m_out_sel[n] = int'(v[n*PER + 16 +: 4]);
        end
        m_conf = (m_out_sel[0] == m_out_sel[1]) && (m_out_sel[0] < W);
    endfunction

    function automatic bit mux_of(input int s);
        if (s < W) return sb_bus_in[s];
        return (s == W + 1);
    endfunction

    function automatic logic [7:0] exp_le_in();
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = m_reg[k] ? m_flop[k] : mux_of(m_in_sel[k]);
        return r;
    endfunction

    function automatic logic [7:0] exp_sb_out();
        logic [7:0] r;
        r = '0;
        for (int t = 0; t < W; t++) begin
            for (int k = 1; k >= 0; k--) begin   // lower index overwrites: it wins
                if (m_out_sel[k] == t) r[t] = le_out[k];
            end
        end
        return r;
    endfunction

    // One clock: check everything at the falling edge, advance the model, return 1ns after the rise.
    task automatic cycle();
        @(negedge clk);
        check("le_in", le_in, exp_le_in());
        check("sb_bus_out", sb_bus_out, exp_sb_out());
        check("config_data_out", config_data_out, hist[0]);
        check("config_done", config_done, m_done);
        check("config_err", config_err, m_err);
        check("config_conflict", config_conflict, m_conf);
        if (rst) begin
            model_reset();
        end else begin
            if (en) for (int k = 0; k < 8; k++) m_flop[k] = mux_of(m_in_sel[k]);
            if (m_done) begin
                m_done = 0;
            end else if (en && config_en) begin
                hist.push_back(config_data_in);
                void'(hist.pop_front());
                if (!m_sess) begin m_sess = 1; m_cnt = 1; m_err = 0; end
                else if (m_cnt < CB) m_cnt++;
            end else if (en && config_commit && m_sess) begin
                m_sess = 0;
                if (m_cnt == CB) begin load_active(); m_done = 1; end
                else m_err = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [47:0] v, input int hi, input int lo, input bit rnd);
        bit e;
        for (int j = hi; j >= lo; j--) begin
            do begin
                e = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
                en = e;
                config_en = 1'b1;
                config_data_in = v[j];
                if (rnd) begin
                    sb_bus_in = 8'($urandom);
                    le_out = 2'($urandom);
                    config_commit = ($urandom_range(0, 3) == 0);
                end
                cycle();
            end while (!e);
        end
        config_en = 1'b0;
        config_commit = 1'b0;
        en = 1'b1;
    endtask

    task automatic do_commit(input bit rnd);
        bit e;
        do begin
            e = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            en = e;
            config_commit = 1'b1;
            cycle();
        end while (!e);
        config_commit = 1'b0;
        en = 1'b1;
    endtask

    logic [47:0] v;
    logic [47:0] g;

    initial begin
        rst = 1'b1; en = 1'b1; config_en = 1'b0; config_data_in = 1'b0;
        config_commit = 1'b0; sb_bus_in = '0; le_out = '0;
        model_reset();

        // ---- reset and idle ----
        cycle(); cycle();
        rst = 1'b0;
        sb_bus_in = 8'hFF; le_out = 2'b11;
        cycle();
        check("rst_le_in", le_in, 8'h00);
        check("rst_sb_out", sb_bus_out, 8'h00);
        check("rst_cdo", config_data_out, 1'b1);
        check("rst_flags", {config_done, config_err, config_conflict}, 3'b000);

        // ---- live reconfiguration ----
        cfg_default(); c_in[0] = 3; c_out[0] = 5;
        v = pack_cfg();
        shift_bits(v, 47, 0, 0);
        do_commit(0);
        cycle();
        sb_bus_in = 8'h08; le_out = 2'b01;
        cycle();
        check("liveA_le_in0", le_in[0], 1'b1);
        check("liveA_sb_out", sb_bus_out, 8'h20);
        cfg_default(); c_in[0] = 1; c_out[0] = 6; c_in[5] = 3;
        v = pack_cfg();
        shift_bits(v, 47, 24, 0);
        check("live_mid_le_in0", le_in[0], 1'b1);
        check("live_mid_sb_out", sb_bus_out, 8'h20);
        shift_bits(v, 23, 0, 0);
        check("live_end_sb_out", sb_bus_out, 8'h20);
        do_commit(0);
        check("liveB_done", config_done, 1'b1);
        check("liveB_le_in", le_in, 8'h20);      // in0<-track1=0, LE1 in1<-track3=1
        check("liveB_sb_out", sb_bus_out, 8'h40);
        cycle();
        check("liveB_done_drop", config_done, 1'b0);

        // ---- short chain ----
        cfg_default(); c_in[0] = 7;
        v = pack_cfg();
        shift_bits(v, 46, 0, 0);
        do_commit(0);
        check("short_err", config_err, 1'b1);
        check("short_no_done", config_done, 1'b0);
        check("short_sb_out", sb_bus_out, 8'h40);
        cycle();
        shift_bits(v, 47, 47, 0);
        check("short_err_clear", config_err, 1'b0);
        shift_bits(v, 46, 0, 0);
        do_commit(0);
        check("short_retry_done", config_done, 1'b1);
        cycle();

        // ---- conflict and priority ----
        cfg_default(); c_out[0] = 2; c_out[1] = 2;
        v = pack_cfg();
        shift_bits(v, 47, 0, 0);
        do_commit(0);
        check("conf_flag", config_conflict, 1'b1);
        le_out = 2'b10;
        cycle();
        check("conf_le0_wins_0", sb_bus_out, 8'h00);
        le_out = 2'b01;
        cycle();
        check("conf_le0_wins_1", sb_bus_out, 8'h04);

        // ---- constants and registered mode ----
        cfg_default(); c_in[4] = 8; c_in[5] = 9; c_in[6] = 0; c_reg[6] = 1;
        v = pack_cfg();
        shift_bits(v, 47, 0, 0);
        do_commit(0);
        sb_bus_in = 8'h00;
        cycle(); cycle();
        check("const0", le_in[4], 1'b0);
        check("const1", le_in[5], 1'b1);
        check("reg_low", le_in[6], 1'b0);
        sb_bus_in = 8'h01;
        #2;
        check("reg_lag", le_in[6], 1'b0);
        cycle();
        check("reg_follow", le_in[6], 1'b1);
        en = 1'b0; sb_bus_in = 8'h00;
        cycle(); cycle();
        check("reg_hold_en0", le_in[6], 1'b1);
        en = 1'b1;
        cycle();
        check("reg_resume", le_in[6], 1'b0);

        // ---- reset mid-shift ----
        cfg_default(); c_in[0] = 2;
        v = pack_cfg();
        shift_bits(v, 47, 28, 0);
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst_cdo", config_data_out, 1'b1);
        check("midrst_le_in", le_in, 8'h00);
        cycle();
        rst = 1'b0;
        shift_bits(v, 47, 0, 0);
        do_commit(0);
        check("midrst_done", config_done, 1'b1);
        check("midrst_err", config_err, 1'b0);
        cycle();

        // ---- randomized reconfiguration against the model ----
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 8; k++) begin
                c_in[k] = $urandom_range(0, 15);
                c_reg[k] = 1'($urandom);
            end
            for (int k = 0; k < 2; k++) c_out[k] = $urandom_range(0, 15);
            v = pack_cfg();
            g = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) shift_bits(g, $urandom_range(0, 3), 0, 1);
            if ($urandom_range(0, 7) == 0) shift_bits(v, 46, 0, 1);
            else                           shift_bits(v, 47, 0, 1);
            do_commit(1);
            repeat ($urandom_range(1, 4)) begin
                en = ($urandom_range(0, 3) != 0);
                sb_bus_in = 8'($urandom);
                le_out = 2'($urandom);
                config_commit = 1'($urandom);
                cycle();
            end
            en = 1'b1;
            config_commit = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
